// File: rtl/char_motion_ctl.sv
// Character motion stage: walk/jump/gravity per frame tick, feeds the platform/collision stage.
// Latency: one cycle after a frame_tick edge. No backpressure; outputs hold between ticks.
// Optional feature macro: DOUBLE_JUMP_EN (one extra jump while airborne).
module char_motion_ctl #(
    parameter int CHAR_HGT  = 48,
    parameter int START_X   = 100,
    parameter int START_Y   = 100,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 976,
    parameter int MOVE_STEP = 4,
    parameter int JUMP_VEL  = 14,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    input  logic        on_ground,
    output logic [11:0] char_x,
    output logic [11:0] char_y,
    output logic [11:0] char_hgt,
    output logic        facing_left,
    output logic        airborne
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    localparam logic [5:0]  P_JUMP = 6'(JUMP_VEL);
    localparam logic [5:0]  P_GRAV = 6'(GRAVITY);
    localparam logic [5:0]  P_MAXF = 6'(MAX_FALL);
    localparam logic [11:0] P_JUMP_Y = 12'(JUMP_VEL);
    localparam logic [12:0] P_STEP = 13'(MOVE_STEP);
    localparam logic [12:0] P_XMIN = 13'(X_MIN);
    localparam logic [12:0] P_XMAX = 13'(X_MAX);

    state_t      r_state;
    logic [5:0]  r_vy;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_facing;
    logic        r_airborne;
    logic        r_jump_prev;

    state_t      w_state_nxt;
    logic [5:0]  w_vy_nxt;
    logic [11:0] w_x_nxt;
    logic [11:0] w_y_nxt;
    logic        w_facing_nxt;
    logic        w_airborne_nxt;
    logic        w_jump_edge;
    logic        w_air_jump;
    logic [5:0]  w_vy_dec;
    logic [6:0]  w_vy_inc;
    logic [5:0]  w_vy_fall;
    logic [12:0] w_y_fall;
    logic [11:0] w_y_jump;
    logic [12:0] w_x_ext;
    logic [12:0] w_x_dec;
    logic [12:0] w_x_inc;

    assign w_jump_edge = btn_jump & ~r_jump_prev;
    assign w_vy_dec    = r_vy - P_GRAV;
    assign w_vy_inc    = {1'b0, r_vy} + {1'b0, P_GRAV};
    assign w_vy_fall   = (w_vy_inc > {1'b0, P_MAXF}) ? P_MAXF : w_vy_inc[5:0];
    assign w_y_fall    = {1'b0, r_y} + {7'd0, w_vy_fall};
    // A jump launched closer than JUMP_VEL to the top pins the character at row 0.
    assign w_y_jump    = (r_y < P_JUMP_Y) ? 12'd0 : (r_y - P_JUMP_Y);
    assign w_x_ext     = {1'b0, r_x};
    assign w_x_dec     = w_x_ext - P_STEP;
    assign w_x_inc     = w_x_ext + P_STEP;

`ifdef DOUBLE_JUMP_EN
    logic r_air_jump_avail;
    logic w_air_jump_avail_nxt;
    assign w_air_jump = w_jump_edge & r_air_jump_avail & (r_state != ST_GROUND);
`else
    assign w_air_jump = 1'b0;
`endif

    // State register: everything advances only on frame ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_FALL;
            r_vy        <= 6'd0;
            r_x         <= 12'(START_X);
            r_y         <= 12'(START_Y);
            r_facing    <= 1'b0;
            r_airborne  <= 1'b1;
            r_jump_prev <= 1'b0;
`ifdef DOUBLE_JUMP_EN
            r_air_jump_avail <= 1'b1;
`endif
        end else if (frame_tick) begin
            r_state     <= w_state_nxt;
            r_vy        <= w_vy_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_facing    <= w_facing_nxt;
            r_airborne  <= w_airborne_nxt;
            r_jump_prev <= btn_jump;
`ifdef DOUBLE_JUMP_EN
            r_air_jump_avail <= w_air_jump_avail_nxt;
`endif
        end
    end

    // Next-state: vertical motion.
    always_comb begin
        w_state_nxt = r_state;
        w_vy_nxt    = r_vy;
        w_y_nxt     = r_y;
        if (w_air_jump) begin
            w_state_nxt = ST_RISE;
            w_vy_nxt    = P_JUMP;
            w_y_nxt     = w_y_jump;
        end else begin
            case (r_state)
                ST_GROUND: begin
                    if (w_jump_edge) begin
                        w_state_nxt = ST_RISE;
                        w_vy_nxt    = P_JUMP;
                        w_y_nxt     = w_y_jump;
                    end else if (!on_ground) begin
                        w_state_nxt = ST_FALL;
                        w_vy_nxt    = 6'd0;
                    end
                end
                ST_RISE: begin
                    if (r_vy <= P_GRAV) begin
                        w_state_nxt = ST_FALL;
                        w_vy_nxt    = 6'd0;
                    end else if (r_y < {6'd0, w_vy_dec}) begin
                        w_state_nxt = ST_FALL;
                        w_vy_nxt    = 6'd0;
                        w_y_nxt     = 12'd0;
                    end else begin
                        w_vy_nxt = w_vy_dec;
                        w_y_nxt  = r_y - {6'd0, w_vy_dec};
                    end
                end
                ST_FALL: begin
                    if (on_ground) begin
                        w_state_nxt = ST_GROUND;
                        w_vy_nxt    = 6'd0;
                    end else begin
                        w_vy_nxt = w_vy_fall;
                        w_y_nxt  = w_y_fall[12] ? 12'hFFF : w_y_fall[11:0];
                    end
                end
                default: begin
                    w_state_nxt = ST_FALL;
                    w_vy_nxt    = 6'd0;
                end
            endcase
        end
    end

    // Outputs: horizontal walk with clamping, airborne flag, air-jump credit.
    always_comb begin
        w_x_nxt        = r_x;
        w_facing_nxt   = r_facing;
        w_airborne_nxt = (w_state_nxt != ST_GROUND);
        if (btn_left && !btn_right) begin
            w_x_nxt      = (w_x_ext < P_XMIN + P_STEP) ? P_XMIN[11:0] : w_x_dec[11:0];
            w_facing_nxt = 1'b1;
        end else if (btn_right && !btn_left) begin
            w_x_nxt      = (w_x_inc > P_XMAX) ? P_XMAX[11:0] : w_x_inc[11:0];
            w_facing_nxt = 1'b0;
        end
`ifdef DOUBLE_JUMP_EN
        w_air_jump_avail_nxt = r_air_jump_avail;
        if (w_air_jump)
            w_air_jump_avail_nxt = 1'b0;
        if (w_state_nxt == ST_GROUND && r_state != ST_GROUND)
            w_air_jump_avail_nxt = 1'b1;
`endif
    end

    assign char_x      = r_x;
    assign char_y      = r_y;
    assign char_hgt    = 12'(CHAR_HGT);
    assign facing_left = r_facing;
    assign airborne    = r_airborne;

endmodule

// File: doc/char_motion_ctl.md
Name: char_motion_ctl

Overview:
- Character motion stage directly upstream of the platform/collision stage.
- Owns the character position and produces `char_x`, `char_y` and `char_hgt`.
- Consumes the `on_ground` flag that the platform stage computes from those values.
- Runs a per-frame walk/jump/gravity state machine driven by button inputs and a one-cycle frame tick.

Parameters:
- CHAR_HGT, 48, character size in pixels; also used as character width by the collision stage.
- START_X, 100, horizontal position after reset.
- START_Y, 100, vertical position after reset (top edge).
- X_MIN, 0, leftmost allowed `char_x`.
- X_MAX, 976, rightmost allowed `char_x` (screen width minus CHAR_HGT).
- MOVE_STEP, 4, horizontal pixels moved per frame while walking.
- JUMP_VEL, 14, initial upward speed in pixels/frame.
- GRAVITY, 1, speed change per frame.
- MAX_FALL, 12, terminal downward speed in pixels/frame.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous reset, active-high.
- frame_tick  in  1  one-cycle pulse once per frame (start of vblank).
- btn_left  in  1  level, move left.
- btn_right  in  1  level, move right.
- btn_jump  in  1  level, jump request (rising edge used).
- on_ground  in  1  from the platform stage; valid combinationally for the current `char_x`/`char_y`.
- char_x  out  12  character left edge, registered.
- char_y  out  12  character top edge, registered.
- char_hgt  out  12  constant CHAR_HGT.
- facing_left  out  1  last horizontal direction, registered.
- airborne  out  1  high when state is RISE or FALL, registered.

Behaviour:
- Interface: single clock `clk`. Reset `rst` is synchronous, active-high. All state updates occur only on a `clk` edge where `frame_tick`=1; outputs hold between ticks.
- Reset values:
  - `char_x`=START_X, `char_y`=START_Y.
  - `facing_left`=0, `airborne`=1.
  - state=FALL, vy=0, jump_prev=0.
- Reset mid-jump or mid-fall discards all motion state.
- Latency: inputs are sampled on the tick edge; new position is visible on the outputs the next cycle.
- Jump edge detect:
  - jump_prev is updated only on ticks.
  - jump_edge = `btn_jump` & !jump_prev.
  - Holding `btn_jump` does not retrigger.
- Horizontal, evaluated every tick in every state:
  - left only: `char_x` = max(`char_x`-MOVE_STEP, X_MIN); `facing_left`=1.
  - right only: `char_x` = min(`char_x`+MOVE_STEP, X_MAX); `facing_left`=0.
  - both pressed or neither: no move; `facing_left` unchanged.
  - Clamp arithmetic uses 13-bit intermediates so there is no wrap-around.
- Vertical state machine; vy is an unsigned 6-bit speed:
  - GROUND:
    - if jump_edge → RISE, vy=JUMP_VEL, `char_y` -= JUMP_VEL.
    - else if !on_ground (walked off an edge) → FALL, vy=0.
    - else `char_y` unchanged.
    - Jump takes priority over walking off an edge.
  - RISE:
    - if vy<=GRAVITY → FALL, vy=0.
    - else vy-=GRAVITY and `char_y` -= vy (new vy).
    - If `char_y` < new vy (ceiling): `char_y`=0 → FALL, vy=0.
    - on_ground is ignored in RISE.
  - FALL:
    - if on_ground → GROUND, vy=0, `char_y` unchanged (no snapping).
    - else vy=min(vy+GRAVITY, MAX_FALL) and `char_y` += vy.
    - `char_y` saturates at 4095.
- `airborne`=1 in RISE and FALL, 0 in GROUND, updated with the state.
- Simultaneous tick and reset: reset wins.
- frame_tick held high for several cycles: each cycle counts as a tick; the bench never does this.

Optional Feature:
- Macro: DOUBLE_JUMP_EN.
- Defined:
  - A 1-bit air_jump_avail is set on entry to GROUND and by reset.
  - In RISE or FALL, a jump_edge with air_jump_avail=1 sets vy=JUMP_VEL, state=RISE, `char_y` -= JUMP_VEL, and clears air_jump_avail.
- Undefined: jump_edge is ignored outside GROUND and no extra register exists.

Test Plan:
- Reset, then 1 tick with on_ground=0 → `char_x`=100, `char_y`=101 (vy=1), `airborne`=1.
- FALL with on_ground forced 1 at `char_y`=200 on next tick → state GROUND, `char_y`=200, `airborne`=0 one cycle after the tick.
- In GROUND at `char_y`=552, pulse btn_jump over 1 tick:
  - tick 1: `char_y`=538.
  - tick 2: `char_y`=525.
  - apex after 14 ticks, then FALL.
  - Holding btn_jump for 30 ticks yields only one jump.
- `char_x`=2, btn_left held for 3 ticks → `char_x`=0, `facing_left`=1. Both buttons held → no change.
- Long fall from `char_y`=0 → vy saturates at 12 (`char_y` increments of 12 after tick 12). Assert rst mid-fall → START_X/START_Y, vy=0 next cycle.
- With DOUBLE_JUMP_EN: jump, then a second jump_edge in RISE restarts vy=14 and a third edge is ignored. Without the macro, the second edge is ignored.
